btime_rom_loader: RTL and testbench

//  Sequences ROM download and core reset for the Burger Time core. Sits between hps_io's ioctl stream and burger_time.

---
 rtl/btime_pkg.sv | 11 +
 rtl/btime_region_dec.sv | 9 +
 rtl/btime_rom_loader.sv | 98 +++++++++
 tb/tb_btime_rom_loader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/btime_pkg.sv
// btime_pkg: shared states, region map and defaults for the Burger Time ROM loader
package btime_pkg;
  localparam logic [16:0] ROM_BYTES_DEF = 17'h1_A000;
  localparam int HOLD_CYCLES_DEF = 1024;
  localparam int NREG_DEF = 4;
  typedef enum logic [2:0] {EMPTY, LOAD, HOLD, RUN, FAIL} state_t;
  typedef enum logic [1:0] {REG_PROG, REG_SOUND, REG_TILES, REG_SPRITES} region_t;
  localparam logic [NREG_DEF-1:0][16:0] REG_BASE = {17'h1_1000, 17'h0_B000, 17'h0_A000, 17'h0_0000};
  localparam logic [16:0] REG_END = ROM_BYTES_DEF;
  localparam logic [NREG_DEF-1:0][16:0] REG_LIM = {REG_END, REG_BASE[REG_SPRITES], REG_BASE[REG_TILES], REG_BASE[REG_SOUND]};
endpackage

// File: rtl/btime_region_dec.sv
// btime_region_dec: maps a download address onto its one-hot ROM region
module btime_region_dec import btime_pkg::*; (
  input  logic [16:0]         addr,
  output logic [NREG_DEF-1:0] region
);
  for (genvar r = 0; r < NREG_DEF; r++) begin : g_reg
    assign region[r] = addr >= REG_BASE[r] && addr < REG_LIM[r];
  end
endmodule

// File: rtl/btime_rom_loader.sv
// btime_rom_loader: re-times ioctl ROM writes into the core and sequences its reset
module btime_rom_loader import btime_pkg::*; #(
  parameter logic [16:0] ROM_BYTES   = ROM_BYTES_DEF,
  parameter int          HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int          NREG        = NREG_DEF
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic            ioctl_download,
  input  logic            ioctl_wr,
  input  logic [24:0]     ioctl_addr,
  input  logic [7:0]      ioctl_dout,
  input  logic            user_reset,
  output logic [16:0]     dn_addr,
  output logic [7:0]      dn_data,
  output logic            dn_wr,
  output logic [NREG-1:0] dn_region,
  output logic            core_reset,
  output logic            load_ok,
  output logic            err_short,
  output logic            err_overflow
);
  localparam int HW = $clog2(HOLD_CYCLES);
  state_t state;
  logic dl_q, dl_rise, dl_fall, in_rom, wr_ok, wr_ovf;
  logic [16:0] byte_cnt, cnt_nxt;
  logic [HW-1:0] hold_cnt;
  logic [NREG_DEF-1:0] region;
  assign dl_rise = ioctl_download & ~dl_q;
  assign dl_fall = ~ioctl_download & dl_q;
  assign in_rom  = ioctl_addr < 25'(ROM_BYTES);
  assign wr_ok   = state == LOAD && ioctl_wr && in_rom;
  assign wr_ovf  = state == LOAD && ioctl_wr && !in_rom;
  assign cnt_nxt = !wr_ok ? byte_cnt : byte_cnt == ROM_BYTES ? byte_cnt : byte_cnt + 17'd1;
  btime_region_dec u_dec (.addr(dn_addr), .region(region));
  assign dn_region = dn_wr ? NREG'(region) : '0;
  // download sequencing, byte counting, hold-off timing and the core write port
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state        <= EMPTY;
      dl_q         <= 1'b0;
      dn_addr      <= '0;
      dn_data      <= '0;
      dn_wr        <= 1'b0;
      core_reset   <= 1'b1;
      load_ok      <= 1'b0;
      err_short    <= 1'b0;
      err_overflow <= 1'b0;
      byte_cnt     <= '0;
      hold_cnt     <= '0;
    end else begin
      dl_q  <= ioctl_download;
      dn_wr <= wr_ok;
      if (wr_ok) begin
        dn_addr <= ioctl_addr[16:0];
        dn_data <= ioctl_dout;
      end
      if (dl_rise && state != LOAD) begin
        state        <= LOAD;
        core_reset   <= 1'b1;
        load_ok      <= 1'b0;
        err_short    <= 1'b0;
        err_overflow <= 1'b0;
        byte_cnt     <= '0;
      end else begin
        case (state)
          LOAD: begin
            byte_cnt <= cnt_nxt;
            if (wr_ovf) err_overflow <= 1'b1;
            if (dl_fall && cnt_nxt == ROM_BYTES) begin
              state    <= HOLD;
              load_ok  <= 1'b1;
              hold_cnt <= '0;
            end else if (dl_fall) begin
              state     <= FAIL;
              err_short <= 1'b1;
            end
          end
          HOLD: begin
            if (user_reset) hold_cnt <= '0;
            else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
              state      <= RUN;
              core_reset <= 1'b0;
            end else hold_cnt <= hold_cnt + HW'(1);
          end
          RUN: begin
            if (user_reset) begin
              state      <= HOLD;
              hold_cnt   <= '0;
              core_reset <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_btime_rom_loader.sv
// tb_btime_rom_loader: vector table plus randomized downloads against a byte-level model
module tb_btime_rom_loader;
  logic clk_sys = 1'b0;
  logic reset_n, ioctl_download, ioctl_wr, user_reset;
  logic [24:0] ioctl_addr;
  logic [7:0] ioctl_dout;
  logic [16:0] a_dn_addr, b_dn_addr, o_dn_addr;
  logic [7:0] a_dn_data, b_dn_data, o_dn_data;
  logic a_dn_wr, b_dn_wr, o_dn_wr;
  logic [3:0] a_dn_region, b_dn_region, o_dn_region;
  logic a_core_reset, b_core_reset, o_core_reset;
  logic a_load_ok, b_load_ok, o_load_ok;
  logic a_err_short, b_err_short, o_err_short;
  logic a_err_overflow, b_err_overflow, o_err_overflow;
  int n_tests = 0;
  int n_fail = 0;
  bit sel = 1'b0;
  int rom = 32'h1_A000;
  int valid;
  bit ovf;
  logic [24:0] q[$];

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic        exp_wr;
    logic [3:0]  exp_reg;
  } vec_t;
  vec_t vt[12];

  always #5 clk_sys = ~clk_sys;

  btime_rom_loader dut_full (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .user_reset(user_reset),
    .dn_addr(a_dn_addr), .dn_data(a_dn_data), .dn_wr(a_dn_wr), .dn_region(a_dn_region),
    .core_reset(a_core_reset), .load_ok(a_load_ok), .err_short(a_err_short), .err_overflow(a_err_overflow)
  );

  btime_rom_loader #(.ROM_BYTES(17'h0_1000)) dut_small (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .user_reset(user_reset),
    .dn_addr(b_dn_addr), .dn_data(b_dn_data), .dn_wr(b_dn_wr), .dn_region(b_dn_region),
    .core_reset(b_core_reset), .load_ok(b_load_ok), .err_short(b_err_short), .err_overflow(b_err_overflow)
  );

  always_comb begin
    o_dn_addr      = sel ? b_dn_addr : a_dn_addr;
    o_dn_data      = sel ? b_dn_data : a_dn_data;
    o_dn_wr        = sel ? b_dn_wr : a_dn_wr;
    o_dn_region    = sel ? b_dn_region : a_dn_region;
    o_core_reset   = sel ? b_core_reset : a_core_reset;
    o_load_ok      = sel ? b_load_ok : a_load_ok;
    o_err_short    = sel ? b_err_short : a_err_short;
    o_err_overflow = sel ? b_err_overflow : a_err_overflow;
  end

  function automatic logic [3:0] region_of(input logic [24:0] a);
    if (a < 25'h0_A000) return 4'b0001;
    if (a < 25'h0_B000) return 4'b0010;
    if (a < 25'h1_1000) return 4'b0100;
    if (a < 25'h1_A000) return 4'b1000;
    return 4'b0000;
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (dut %s)", nm, act, exp, sel ? "small" : "full");
    end
  endtask

  task automatic use_dut(input bit s);
    sel = s;
    rom = s ? 32'h1000 : 32'h1_A000;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input bit fall);
    bit ok;
    ok = a < rom;
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (fall) ioctl_download = 1'b0;
    tick();
    ioctl_wr = 1'b0;
    chk("dn_wr", o_dn_wr, ok);
    if (ok) begin
      chk("dn_addr", o_dn_addr, a[16:0]);
      chk("dn_data", o_dn_data, d);
      chk("dn_region", o_dn_region, region_of(a));
      valid++;
    end else begin
      chk("dn_region_drop", o_dn_region, 4'b0000);
      ovf = 1'b1;
    end
  endtask

  task automatic run_load(input bit fall_last);
    valid = 0;
    ovf = 1'b0;
    ioctl_download = 1'b1;
    tick();
    tick();
    chk("load_core_reset", o_core_reset, 1'b1);
    chk("load_ok_cleared", o_load_ok, 1'b0);
    foreach (q[i]) begin
      wr_byte(q[i], 8'($urandom), fall_last && i == q.size() - 1);
      if (!(fall_last && i == q.size() - 1) && $urandom_range(3) == 0) begin
        tick();
        chk("dn_wr_gap", o_dn_wr, 1'b0);
      end
    end
    if (!fall_last || q.size() == 0) begin
      ioctl_download = 1'b0;
      tick();
    end
    chk("load_ok", o_load_ok, valid >= rom);
    chk("err_short", o_err_short, valid < rom);
    chk("err_overflow", o_err_overflow, ovf);
    chk("hold_core_reset", o_core_reset, 1'b1);
  endtask

  task automatic wait_release();
    int k;
    k = 0;
    while (o_core_reset && k < 3000) begin
      tick();
      k++;
    end
    chk("release_delay", k, 1024);
  endtask

  task automatic fill_seq(input int n);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(25'(i));
  endtask

  initial begin
    vt[0]  = '{25'h000_0000, 8'h11, 1'b1, 4'b0001};
    vt[1]  = '{25'h000_9FFF, 8'h22, 1'b1, 4'b0001};
    vt[2]  = '{25'h000_A000, 8'h33, 1'b1, 4'b0010};
    vt[3]  = '{25'h000_AFFF, 8'h44, 1'b1, 4'b0010};
    vt[4]  = '{25'h000_B000, 8'h5A, 1'b1, 4'b0100};
    vt[5]  = '{25'h001_0FFF, 8'h66, 1'b1, 4'b0100};
    vt[6]  = '{25'h001_1000, 8'h77, 1'b1, 4'b1000};
    vt[7]  = '{25'h001_9FFF, 8'h88, 1'b1, 4'b1000};
    vt[8]  = '{25'h001_A000, 8'h99, 1'b0, 4'b0000};
    vt[9]  = '{25'h001_A00F, 8'hAA, 1'b0, 4'b0000};
    vt[10] = '{25'h001_FFFF, 8'hBB, 1'b0, 4'b0000};
    vt[11] = '{25'h100_0005, 8'hCC, 1'b0, 4'b0000};
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    user_reset = 1'b0;
    use_dut(1'b0);
    tick();
    tick();
    chk("rst_core_reset", o_core_reset, 1'b1);
    chk("rst_load_ok", o_load_ok, 1'b0);
    chk("rst_dn_wr", o_dn_wr, 1'b0);
    chk("rst_dn_addr", o_dn_addr, 17'h0);
    chk("rst_dn_data", o_dn_data, 8'h0);
    chk("rst_dn_region", o_dn_region, 4'h0);
    chk("rst_err_short", o_err_short, 1'b0);
    chk("rst_err_overflow", o_err_overflow, 1'b0);
    reset_n = 1'b1;
    user_reset = 1'b1;
    repeat (3) tick();
    user_reset = 1'b0;
    chk("empty_core_reset", o_core_reset, 1'b1);
    ioctl_download = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 12; i++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = vt[i].addr;
      ioctl_dout = vt[i].data;
      tick();
      ioctl_wr = 1'b0;
      chk("vec_dn_wr", o_dn_wr, vt[i].exp_wr);
      chk("vec_dn_region", o_dn_region, vt[i].exp_reg);
      if (vt[i].exp_wr) begin
        chk("vec_dn_addr", o_dn_addr, vt[i].addr[16:0]);
        chk("vec_dn_data", o_dn_data, vt[i].data);
      end
      tick();
      chk("vec_dn_wr_pulse", o_dn_wr, 1'b0);
    end
    ioctl_download = 1'b0;
    tick();
    chk("vec_err_short", o_err_short, 1'b1);
    chk("vec_err_overflow", o_err_overflow, 1'b1);
    chk("vec_load_ok", o_load_ok, 1'b0);
    fill_seq(32'h100);
    run_load(1'b0);
    user_reset = 1'b1;
    repeat (2) tick();
    user_reset = 1'b0;
    repeat (1500) tick();
    chk("fail_core_reset", o_core_reset, 1'b1);
    chk("fail_err_short", o_err_short, 1'b1);
    use_dut(1'b1);
    chk("fail_core_reset_small", o_core_reset, 1'b1);
    chk("fail_err_short_small", o_err_short, 1'b1);
    ioctl_download = 1'b1;
    tick();
    ioctl_download = 1'b0;
    tick();
    chk("zero_err_short", o_err_short, 1'b1);
    chk("zero_load_ok", o_load_ok, 1'b0);
    repeat (5) tick();
    chk("zero_core_reset", o_core_reset, 1'b1);
    fill_seq(rom);
    run_load(1'b1);
    wait_release();
    chk("run_load_ok", o_load_ok, 1'b1);
    chk("run_err_short", o_err_short, 1'b0);
    chk("run_err_overflow", o_err_overflow, 1'b0);
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
    chk("ureset_edge", o_core_reset, 1'b1);
    repeat (500) tick();
    chk("ureset_mid_hold", o_core_reset, 1'b1);
    user_reset = 1'b1;
    repeat (3) tick();
    user_reset = 1'b0;
    wait_release();
    chk("ureset_load_ok", o_load_ok, 1'b1);
    fill_seq(rom);
    for (int i = 0; i < 16; i++) q.insert($urandom_range(q.size()), 25'(rom + i));
    for (int i = 0; i < 3; i++) q.insert($urandom_range(q.size()), 25'($urandom_range(rom - 1)));
    run_load(1'b0);
    wait_release();
    chk("ovf_still_flag", o_err_overflow, 1'b1);
    ioctl_download = 1'b1;
    tick();
    tick();
    chk("abort_load_core_reset", o_core_reset, 1'b1);
    chk("abort_load_ok", o_load_ok, 1'b0);
    for (int i = 0; i < 32'h800; i++) wr_byte(25'(i), 8'($urandom), 1'b0);
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    tick();
    chk("abort_core_reset", o_core_reset, 1'b1);
    chk("abort_load_ok_rst", o_load_ok, 1'b0);
    chk("abort_dn_wr", o_dn_wr, 1'b0);
    chk("abort_dn_addr", o_dn_addr, 17'h0);
    reset_n = 1'b1;
    repeat (20) tick();
    chk("abort_empty", o_core_reset, 1'b1);
    fill_seq(rom - 1);
    run_load(1'b0);
    fill_seq(rom - 1);
    q.insert($urandom_range(q.size()), 25'($urandom_range(rom - 2)));
    run_load(1'b1);
    wait_release();
    chk("final_load_ok", o_load_ok, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
